// File: rtl/prog_writer.sv
// prog_writer: turns a stream of instruction requests into encoded 9-bit
// words and writes them sequentially into an instruction memory. Each
// accepted request produces one write cycle. A HALT word completes the
// image (DONE). A reserved kind or running past the last address is a
// sticky error (ERR). Both DONE and ERR hold until reset.
module prog_writer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [5:0]        in_payload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_ACCEPT = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [2:0] K_R_R0 = 3'd0;
    localparam logic [2:0] K_R_RN = 3'd1;
    localparam logic [2:0] K_LB   = 3'd2;
    localparam logic [2:0] K_SB   = 3'd3;
    localparam logic [2:0] K_BR   = 3'd4;
    localparam logic [2:0] K_IMM  = 3'd5;
    localparam logic [2:0] K_HALT = 3'd6;
    localparam logic [2:0] K_RSVD = 3'd7;

    // Highest memory address; a non-HALT write here fills the memory.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [8:0]        wdata_q,      wdata_d;
    logic              halt_q,       halt_d;

    logic [8:0]        enc_word;

    // Encode the offered request: 2-bit opcode, payload in [6:1], variant bit.
    always_comb begin
        enc_word = 9'd0;
        case (in_kind)
            K_R_R0:  enc_word = {2'b00, in_payload, 1'b0};
            K_R_RN:  enc_word = {2'b00, in_payload, 1'b1};
            K_LB:    enc_word = {2'b01, in_payload, 1'b0};
            K_SB:    enc_word = {2'b01, in_payload, 1'b1};
            K_BR:    enc_word = {2'b10, in_payload, 1'b0};
            K_IMM:   enc_word = {2'b11, in_payload, 1'b0};
            K_HALT:  enc_word = {2'b11, 6'b000000, 1'b1};
            default: enc_word = 9'd0;
        endcase
    end

    // Next-state logic: capture the word on handshake, commit it in WRITE.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        halt_d       = halt_q;
        case (state_q)
            S_ACCEPT: begin
                if (in_valid) begin
                    if (in_kind == K_RSVD) begin
                        // Reserved kind: no write, pointer and count untouched.
                        state_d = S_ERR;
                    end else begin
                        // The write port registers double as the hold
                        // registers, so address and data stay put after WRITE.
                        state_d = S_WRITE;
                        addr_d  = wr_ptr_q;
                        wdata_d = enc_word;
                        halt_d  = (in_kind == K_HALT);
                    end
                end
            end
            S_WRITE: begin
                wr_ptr_d     = wr_ptr_q + 1'b1;
                word_count_d = word_count_q + 1'b1;
                // HALT wins over memory-full, even at the last address.
                if (halt_q) begin
                    state_d = S_DONE;
                end else if (wr_ptr_q == LAST_ADDR) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: begin
                // DONE and ERR are absorbing until reset.
                state_d = state_q;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_ACCEPT;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            halt_q       <= halt_d;
        end
    end

    assign in_ready   = (state_q == S_ACCEPT);
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = word_count_q;
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_writer.sv
// Bench for prog_writer (ADDR_W=2, four-word memory): a transaction-level
// model predicts every output each cycle; directed scenarios add literal
// expectations for the written words and end conditions.
module tb_prog_writer;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_kind = 3'd0;
    logic [5:0]    in_payload = 6'd0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [8:0]    imem_wdata;
    logic [AW:0]   word_count;
    logic          done;
    logic          err;

    int checks = 0;
    int failures = 0;

    prog_writer #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_payload (in_payload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Instruction encoding from the opcode table, as plain arithmetic.
    function automatic logic [8:0] encode(input logic [2:0] k, input logic [5:0] p);
        int op;
        int lsb;
        if (k == 3'd6) return 9'h181;
        op  = (k < 3'd2) ? 0 : (k < 3'd4) ? 1 : (k == 3'd4) ? 2 : 3;
        lsb = (k == 3'd1 || k == 3'd3) ? 1 : 0;
        return 9'(op * 128 + int'(p) * 2 + lsb);
    endfunction

    // Transaction-level model: busy = one write cycle pending after a handshake.
    bit            m_live = 0;
    bit            m_busy, m_done, m_err, m_halt;
    int            m_count;
    logic [AW-1:0] m_addr;
    logic [8:0]    m_data;

    always @(posedge clk) begin
        if (reset) begin
            m_live  <= 1;
            m_busy  <= 0;
            m_done  <= 0;
            m_err   <= 0;
            m_halt  <= 0;
            m_count <= 0;
            m_addr  <= '0;
            m_data  <= '0;
        end else if (m_busy) begin
            m_busy  <= 0;
            m_count <= m_count + 1;
            if (m_halt) m_done <= 1;
            else if (m_count + 1 == DEPTH) m_err <= 1;
        end else if (!m_done && !m_err && in_valid) begin
            if (in_kind == 3'd7) begin
                m_err <= 1;
            end else begin
                m_busy <= 1;
                m_addr <= AW'(m_count % DEPTH);
                m_data <= encode(in_kind, in_payload);
                m_halt <= (in_kind == 3'd6);
            end
        end
    end

    // Write log captured from the memory port for the literal checks.
    int         nwr = 0;
    logic [AW-1:0] log_addr [8];
    logic [8:0]    log_data [8];

    // Compare process: every cycle after the first reset, all outputs vs model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("cycle_outputs",
                32'({in_ready, imem_we, imem_addr, imem_wdata, word_count, done, err}),
                32'({!m_busy && !m_done && !m_err, m_busy, m_addr, m_data,
                     (AW+1)'(m_count), m_done, m_err}));
        end
        if (imem_we === 1'b1) begin
            if (nwr < 8) begin
                log_addr[nwr] = imem_addr;
                log_data[nwr] = imem_wdata;
            end
            nwr = nwr + 1;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        nwr = 0;
    endtask

    // Offer a request and return at the negedge following its acceptance.
    task automatic send(input logic [2:0] k, input logic [5:0] p);
        bit ok = 0;
        in_valid = 1'b1;
        in_kind = k;
        in_payload = p;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready === 1'b1) ok = 1;
            @(negedge clk);
        end
        if (ok) begin
            $display("XFER kind=%0d payload=%02h", k, p);
        end else begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout actual=no_accept required=accept kind=%0d", k);
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_outputs", 32'({imem_we, imem_addr, imem_wdata, done, err}), 32'd0);

        // LB then SB, payload 5
        send(3'd2, 6'b000101);
        send(3'd3, 6'b000101);
        in_valid = 1'b0;
        idle(3);
        chk("lbsb_nwr", 32'(nwr), 32'd2);
        chk("lbsb_addr0", 32'(log_addr[0]), 32'd0);
        chk("lbsb_data0", 32'(log_data[0]), 32'h08A);
        chk("lbsb_addr1", 32'(log_addr[1]), 32'd1);
        chk("lbsb_data1", 32'(log_data[1]), 32'h08B);
        chk("lbsb_count", 32'(word_count), 32'd2);

        // Continuous valid, four kinds with payload 3F (fills the 4-word memory)
        do_reset();
        send(3'd0, 6'h3F);
        send(3'd1, 6'h3F);
        send(3'd4, 6'h3F);
        send(3'd5, 6'h3F);
        in_valid = 1'b0;
        idle(3);
        chk("b2b_nwr", 32'(nwr), 32'd4);
        chk("b2b_data0", 32'(log_data[0]), 32'h07E);
        chk("b2b_data1", 32'(log_data[1]), 32'h07F);
        chk("b2b_data2", 32'(log_data[2]), 32'h17E);
        chk("b2b_data3", 32'(log_data[3]), 32'h1FE);
        chk("b2b_addr3", 32'(log_addr[3]), 32'd3);
        chk("b2b_full_err", 32'(err), 32'd1);

        // IMM then HALT (payload ignored), further requests ignored
        do_reset();
        send(3'd5, 6'h15);
        send(3'd6, 6'h2A);
        in_kind = 3'd0;
        idle(5);
        in_valid = 1'b0;
        chk("halt_data0", 32'(log_data[0]), 32'h1AA);
        chk("halt_addr1", 32'(log_addr[1]), 32'd1);
        chk("halt_data1", 32'(log_data[1]), 32'h181);
        chk("halt_done", 32'({done, err, in_ready}), 32'b100);
        chk("halt_nwr", 32'(nwr), 32'd2);

        // Memory full: four R_R0 then an extra offer
        do_reset();
        for (int i = 0; i < 4; i++) send(3'd0, 6'(i));
        idle(5);
        in_valid = 1'b0;
        chk("full_nwr", 32'(nwr), 32'd4);
        chk("full_last_addr", 32'(log_addr[3]), 32'd3);
        chk("full_err", 32'({done, err}), 32'b01);
        chk("full_count", 32'(word_count), 32'd4);

        // Three R_R0 then HALT at the last address: done, not err
        do_reset();
        for (int i = 0; i < 3; i++) send(3'd0, 6'(i + 8));
        send(3'd6, 6'h3F);
        in_valid = 1'b0;
        idle(3);
        chk("lasthalt_addr", 32'(log_addr[3]), 32'd3);
        chk("lasthalt_data", 32'(log_data[3]), 32'h181);
        chk("lasthalt_flags", 32'({done, err}), 32'b10);
        chk("lasthalt_count", 32'(word_count), 32'd4);

        // Reserved kind after one word
        do_reset();
        send(3'd0, 6'h01);
        send(3'd7, 6'h09);
        in_valid = 1'b0;
        chk("rsvd_err_next", 32'({err, in_ready}), 32'b10);
        idle(3);
        chk("rsvd_nwr", 32'(nwr), 32'd1);
        chk("rsvd_count", 32'(word_count), 32'd1);
        chk("rsvd_err_hold", 32'(err), 32'd1);

        // Reset during the WRITE cycle
        do_reset();
        send(3'd1, 6'h11);
        reset = 1'b1;
        in_valid = 1'b0;
        idle(1);
        chk("midrst_we", 32'(imem_we), 32'd0);
        chk("midrst_count", 32'(word_count), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        nwr = 0;
        send(3'd2, 6'h03);
        in_valid = 1'b0;
        idle(2);
        chk("midrst_next_nwr", 32'(nwr), 32'd1);
        chk("midrst_next_addr", 32'(log_addr[0]), 32'd0);
        chk("midrst_next_data", 32'(log_data[0]), 32'h086);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
